instr_prefetch_unit: RTL

//  Instruction-fetch master placed directly upstream of the code-memory bus port.

---
 rtl/instr_prefetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - sequential instruction prefetcher feeding a DEPTH-entry FIFO
//
// Purpose:
//   Instruction-fetch master that sits in front of the code-memory bus port.
//   It issues sequential word reads (one-cycle synchronous read latency) and
//   queues each returned word together with its PC. The core drains the queue
//   with a valid/ready handshake. A redirect flushes the queue, drops the word
//   in flight and restarts fetch at the new PC.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
//
// Ports:
//   iCLK, iRST                 clock, asynchronous active-high reset
//   iRedirect, iRedirectPC     flush and restart fetch at iRedirectPC
//   iInstrReady                core accepts the FIFO head this cycle
//   oInstrValid/oInstr/oInstrPC FIFO head (oInstr/oInstrPC hold when empty)
//   oMisaligned                sticky misaligned-redirect flag
//   oReadEnable/oAddress       bus read strobe and word address
//   oWriteEnable/oByteEnable   tied to 0 / 4'hF
//   iReadData                  bus read data, valid the cycle after oReadEnable
//
// Optional feature macro: IPF_ALIGN_CHECK_EN
//   Defined: a redirect with iRedirectPC[1:0] != 0 sets oMisaligned and halts
//   fetch until an aligned redirect arrives.
//   Undefined: the low two redirect bits are ignored and oMisaligned is 0.

module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    input  logic        iInstrReady,
    output logic        oInstrValid,
    output logic [31:0] oInstr,
    output logic [31:0] oInstrPC,
    output logic        oMisaligned,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    input  logic [31:0] iReadData
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_last_instr;
    logic [31:0]   r_last_pc;

    logic [31:0]   w_redirect_target;
    logic          w_redirect_bad;
    logic [AW:0]   w_credit_used;
    logic          w_fifo_valid;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    assign w_redirect_target = {iRedirectPC[31:2], 2'b00};

`ifdef IPF_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_redirect_bad = iRedirect && (iRedirectPC[1:0] != 2'b00);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_misaligned <= 1'b0;
        end else if (iRedirect) begin
            r_misaligned <= w_redirect_bad;
        end
    end

    assign oMisaligned = r_misaligned;
`else
    logic w_unused_low_pc;

    assign w_redirect_bad  = 1'b0;
    assign w_unused_low_pc = ^iRedirectPC[1:0];
    assign oMisaligned     = 1'b0;
`endif

    // Words already queued plus the word returning next cycle; a new read is
    // only issued when both fit, so a push never targets a full FIFO.
    assign w_credit_used = r_count + {{AW{1'b0}}, r_inflight};
    assign w_fifo_valid  = (r_count != '0);
    assign w_issue       = (r_state == S_RUN) && !iRedirect && (w_credit_used < DEPTH_C);
    assign w_push        = r_inflight && !iRedirect;
    assign w_pop         = w_fifo_valid && iInstrReady && !iRedirect;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_START: w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_START;
        endcase
        if (iRedirect) begin
            if (w_redirect_bad) begin
                w_state_next = S_HALT;
            end else if (r_state == S_HALT) begin
                w_state_next = S_RUN;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else if (iRedirect) begin
            // Clearing r_inflight here drops the word issued this cycle's
            // predecessor; push and pop are already gated off above.
            r_fetch_pc <= w_redirect_target;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= iReadData;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Remembers the most recently presented head so the outputs hold steady
    // while the FIFO is empty.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_last_instr <= 32'h0;
            r_last_pc    <= 32'h0;
        end else if (w_fifo_valid) begin
            r_last_instr <= r_mem_instr[r_rd_ptr];
            r_last_pc    <= r_mem_pc[r_rd_ptr];
        end
    end

    assign oInstrValid  = w_fifo_valid;
    assign oInstr       = w_fifo_valid ? r_mem_instr[r_rd_ptr] : r_last_instr;
    assign oInstrPC     = w_fifo_valid ? r_mem_pc[r_rd_ptr]    : r_last_pc;
    assign oReadEnable  = w_issue;
    assign oAddress     = r_fetch_pc;
    assign oWriteEnable = 1'b0;
    assign oByteEnable  = 4'hF;

endmodule
